// File: rtl/imm_pkg.sv
// Shared opcode constants, format codes and helpers for the immediate-generation stage.
package imm_pkg;

   localparam int unsigned IR_W  = 32;
   localparam int unsigned FMT_W = 3;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [FMT_W-1:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

   // Sign-extend a 32-bit immediate to the widest supported datapath.
   function automatic logic [63:0] sext64(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-format classifier and immediate extractor.
module imm_decode
   import imm_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter bit          EN_ZICSR = 1'b1
) (
   input  logic [IR_W-1:0] ir,
   output logic [XLEN-1:0] imm_c,
   output imm_fmt_e        fmt_c,
   output logic            illegal_c
);

   logic [31:0] imm32;
   logic [2:0]  funct3;

   assign funct3 = ir[14:12];

   always_comb begin
      imm32     = '0;
      fmt_c     = FMT_NONE;
      illegal_c = 1'b0;
      if (ir[1:0] != 2'b11) begin
         illegal_c = 1'b1;
      end else begin
         case (ir[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
               fmt_c = FMT_I;
               imm32 = {{20{ir[31]}}, ir[31:20]};
            end
            OPC_OP_IMM_32: begin
               if (XLEN == 64) begin
                  fmt_c = FMT_I;
                  imm32 = {{20{ir[31]}}, ir[31:20]};
               end else begin
                  illegal_c = 1'b1;
               end
            end
            OPC_STORE: begin
               fmt_c = FMT_S;
               imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OPC_BRANCH: begin
               fmt_c = FMT_B;
               imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
               fmt_c = FMT_U;
               imm32 = {ir[31:12], 12'b0};
            end
            OPC_JAL: begin
               fmt_c = FMT_J;
               imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
               // Register-operand CSR forms carry no immediate but stay legal with Zicsr.
               if (funct3 == 3'b000) begin
                  fmt_c = FMT_NONE;
               end else if (!EN_ZICSR) begin
                  illegal_c = 1'b1;
               end else if (funct3[2]) begin
                  fmt_c = FMT_Z;
                  imm32 = {27'b0, ir[19:15]};
               end
            end
            OPC_OP: begin
               fmt_c = FMT_NONE;
            end
            OPC_OP_32: begin
               if (XLEN != 64) illegal_c = 1'b1;
            end
            default: begin
               illegal_c = 1'b1;
            end
         endcase
      end
   end

   assign imm_c = XLEN'(sext64(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage with valid/ready handshake and optional skid buffer.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter bit          EN_ZICSR = 1'b1,
   parameter bit          SKID     = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IR_W-1:0]   in_ir,
   input  logic [XLEN-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_target,
   output logic [FMT_W-1:0]  out_fmt,
   output logic              out_illegal,
   output logic [XLEN-1:0]   out_pc
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pc;
      imm_fmt_e        fmt;
      logic            illegal;
   } entry_t;

   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   logic            dec_illegal;

   entry_t new_entry;
   entry_t main_q, main_d, skid_q, skid_d;
   logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic   rdy_q, rdy_d;
   logic   accept, retire;

   imm_decode #(
      .XLEN     (XLEN),
      .EN_ZICSR (EN_ZICSR)
   ) u_decode (
      .ir        (in_ir),
      .imm_c     (dec_imm),
      .fmt_c     (dec_fmt),
      .illegal_c (dec_illegal)
   );

   always_comb begin
      new_entry.imm     = dec_imm;
      new_entry.target  = in_pc + dec_imm;
      new_entry.pc      = in_pc;
      new_entry.fmt     = dec_fmt;
      new_entry.illegal = dec_illegal;
   end

   // Without the skid register the ready path passes straight through from out_ready.
   assign in_ready = (SKID != 1'b0) ? rdy_q : (!main_v_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign retire   = main_v_q && out_ready;

   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (retire) begin
         if (skid_v_q) begin
            main_d   = skid_q;
            skid_v_d = accept;
            if (accept) skid_d = new_entry;
         end else if (accept) begin
            main_d = new_entry;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_v_q) begin
            main_d   = new_entry;
            main_v_d = 1'b1;
         end else begin
            skid_d   = new_entry;
            skid_v_d = 1'b1;
         end
      end
      rdy_d = !(main_v_d && skid_v_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         rdy_q    <= rdy_d;
      end
   end

   assign out_valid   = main_v_q;
   assign out_imm     = main_q.imm;
   assign out_target  = main_q.target;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;
   assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: default configuration plus an XLEN=64, no-Zicsr, no-skid instance.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_ir, in_pc;
   logic [63:0] in_pc64;

   logic        rdy, ov, ill;
   logic [31:0] imm, tgt, pc;
   logic [2:0]  fmt;

   logic        a_rdy, a_ov, a_ill;
   logic [63:0] a_imm, a_tgt, a_pc;
   logic [2:0]  a_fmt;

   int checks = 0;
   int errors = 0;

   assign in_pc64 = {32'b0, in_pc};

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1'b1), .SKID(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy),
      .in_ir(in_ir), .in_pc(in_pc), .out_valid(ov), .out_ready(out_ready),
      .out_imm(imm), .out_target(tgt), .out_fmt(fmt), .out_illegal(ill), .out_pc(pc)
   );

   imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1'b0), .SKID(1'b0)) dut_alt (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
      .in_ir(in_ir), .in_pc(in_pc64), .out_valid(a_ov), .out_ready(out_ready),
      .out_imm(a_imm), .out_target(a_tgt), .out_fmt(a_fmt), .out_illegal(a_ill), .out_pc(a_pc)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single cycle with out_ready high; the entry is visible on return.
   task automatic drive_one(input logic [31:0] ir, input logic [31:0] p);
      in_valid  = 1'b1;
      in_ir     = ir;
      in_pc     = p;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ir = '0; in_pc = '0;
      #12;
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ov); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready_skid got %b want 0", rdy); end
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready_noskid got %b want 1", a_rdy); end
      checks++; if ({imm, tgt, pc} !== 96'h0) begin errors++; $display("FAIL reset_payload got %h %h %h want 0", imm, tgt, pc); end
      checks++; if ({fmt, ill} !== 4'h0) begin errors++; $display("FAIL reset_fmt_ill got %h %b want 0 0", fmt, ill); end
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_valid_alt got %b want 0", a_ov); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", rdy); end
   endtask

   task automatic test_i_type();
      drive_one(32'hFFF00093, 32'h100);
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", ov); end
      checks++; if (imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", imm); end
      checks++; if (fmt !== 3'd1 || ill !== 1'b0) begin errors++; $display("FAIL addi_fmt got %0d/%b want 1/0", fmt, ill); end
      checks++; if (tgt !== 32'hFF) begin errors++; $display("FAIL addi_target got %h want 000000ff", tgt); end
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 00000100", pc); end
      checks++; if (a_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi64_imm got %h want ffffffffffffffff", a_imm); end
      checks++; if (a_tgt !== 64'hFF) begin errors++; $display("FAIL addi64_target got %h want ff", a_tgt); end
   endtask

   task automatic test_back_to_back();
      drive_one(32'hFE20AE23, 32'h100);
      checks++; if (imm !== 32'hFFFFFFFC || fmt !== 3'd2) begin errors++; $display("FAIL sw_imm got %h/%0d want fffffffc/2", imm, fmt); end
      checks++; if (tgt !== 32'hFC) begin errors++; $display("FAIL sw_target got %h want 000000fc", tgt); end
      drive_one(32'hFE000CE3, 32'h100);
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL beq_valid got %b want 1", ov); end
      checks++; if (imm !== 32'hFFFFFFF8 || fmt !== 3'd3) begin errors++; $display("FAIL beq_imm got %h/%0d want fffffff8/3", imm, fmt); end
      checks++; if (tgt !== 32'hF8) begin errors++; $display("FAIL beq_target got %h want 000000f8", tgt); end
   endtask

   task automatic test_u_z_j();
      drive_one(32'h123450B7, 32'h100);
      checks++; if (imm !== 32'h12345000 || fmt !== 3'd4) begin errors++; $display("FAIL lui_imm got %h/%0d want 12345000/4", imm, fmt); end
      checks++; if (tgt !== 32'h12345100) begin errors++; $display("FAIL lui_target got %h want 12345100", tgt); end
      drive_one(32'h305FD073, 32'h100);
      checks++; if (imm !== 32'h1F || fmt !== 3'd6 || ill !== 1'b0) begin errors++; $display("FAIL csrrwi got %h/%0d/%b want 1f/6/0", imm, fmt, ill); end
      checks++; if (a_ill !== 1'b1 || a_fmt !== 3'd0 || a_imm !== 64'h0) begin errors++; $display("FAIL csrrwi_nozicsr got %b/%0d/%h want 1/0/0", a_ill, a_fmt, a_imm); end
      drive_one(32'hFFDFF0EF, 32'h100);
      checks++; if (imm !== 32'hFFFFFFFC || fmt !== 3'd5) begin errors++; $display("FAIL jal_imm got %h/%0d want fffffffc/5", imm, fmt); end
      checks++; if (a_tgt !== 64'hFC) begin errors++; $display("FAIL jal64_target got %h want fc", a_tgt); end
      drive_one(32'h002081B3, 32'h100);
      checks++; if (imm !== 32'h0 || fmt !== 3'd0 || ill !== 1'b0) begin errors++; $display("FAIL op_add got %h/%0d/%b want 0/0/0", imm, fmt, ill); end
      drive_one(32'h00000073, 32'h100);
      checks++; if (fmt !== 3'd0 || ill !== 1'b0 || a_ill !== 1'b0) begin errors++; $display("FAIL ecall got %0d/%b/%b want 0/0/0", fmt, ill, a_ill); end
   endtask

   task automatic test_illegal();
      drive_one(32'h00000000, 32'h100);
      checks++; if (ill !== 1'b1 || fmt !== 3'd0 || imm !== 32'h0) begin errors++; $display("FAIL zero_word got %b/%0d/%h want 1/0/0", ill, fmt, imm); end
      drive_one(32'h0000007F, 32'h100);
      checks++; if (ill !== 1'b1 || fmt !== 3'd0 || imm !== 32'h0) begin errors++; $display("FAIL opc_7f got %b/%0d/%h want 1/0/0", ill, fmt, imm); end
      drive_one(32'h0010009B, 32'h100);
      checks++; if (ill !== 1'b1 || fmt !== 3'd0) begin errors++; $display("FAIL addiw_rv32 got %b/%0d want 1/0", ill, fmt); end
      checks++; if (a_ill !== 1'b0 || a_fmt !== 3'd1 || a_imm !== 64'h1) begin errors++; $display("FAIL addiw_rv64 got %b/%0d/%h want 0/1/1", a_ill, a_fmt, a_imm); end
      out_ready = 1'b1;
      tick();
      checks++; if (ov !== 1'b0 || a_ov !== 1'b0) begin errors++; $display("FAIL drain_empty got %b/%b want 0/0", ov, a_ov); end
   endtask

   task automatic test_skid();
      int acc_n = 0;
      int ret_n = 0;
      logic do_acc, do_ret;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid  = (acc_n < 5);
         in_ir     = {12'(acc_n + 1), 20'h00093};
         in_pc     = 32'h200 + 32'(4 * acc_n);
         out_ready = !(cyc >= 1 && cyc <= 3);
         #1;
         if (cyc == 2) begin
            checks++; if (acc_n != 2 || rdy !== 1'b0) begin errors++; $display("FAIL skid_full got acc=%0d rdy=%b want 2/0", acc_n, rdy); end
         end
         if (cyc == 2 || cyc == 3) begin
            checks++; if (ov !== 1'b1 || imm !== 32'h1) begin errors++; $display("FAIL skid_stall_hold got %b/%h want 1/00000001", ov, imm); end
         end
         if (cyc == 5) begin
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL skid_ready_back got %b want 1", rdy); end
         end
         do_acc = in_valid && rdy;
         do_ret = ov && out_ready;
         if (do_ret) begin
            checks++;
            if (imm !== 32'(ret_n + 1) || pc !== 32'h200 + 32'(4 * ret_n)) begin
               errors++; $display("FAIL skid_order_%0d got %h/%h want %h/%h", ret_n, imm, pc, 32'(ret_n + 1), 32'h200 + 32'(4 * ret_n));
            end
            ret_n++;
         end
         if (do_acc) acc_n++;
         tick();
      end
      in_valid = 1'b0;
      checks++; if (ret_n != 5 || ov !== 1'b0) begin errors++; $display("FAIL skid_total got %0d/%b want 5/0", ret_n, ov); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      tick();
      in_valid = 1'b1; in_ir = 32'h00500093; in_pc = 32'h300; out_ready = 1'b0;
      tick();
      checks++; if (ov !== 1'b1 || a_ov !== 1'b1) begin errors++; $display("FAIL flush_pre got %b/%b want 1/1", ov, a_ov); end
      in_ir = 32'h00600093; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (ov !== 1'b0 || a_ov !== 1'b0) begin errors++; $display("FAIL flush_clear got %b/%b want 0/0", ov, a_ov); end
      tick();
      checks++; if (ov !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL flush_discard got %b/%b want 0/1", ov, rdy); end
   endtask

   task automatic test_skid0_ready();
      in_valid = 1'b1; in_ir = 32'h00700093; in_pc = 32'h400; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL noskid_stall_ready got %b want 0", a_rdy); end
      out_ready = 1'b1;
      #1;
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL noskid_comb_ready got %b want 1", a_rdy); end
      tick();
      checks++; if (a_ov !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL noskid_retire got %b/%b want 0/0", a_ov, ov); end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_ir = 32'h00800093; in_pc = 32'h500; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b want 1", ov); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ov !== 1'b0 || a_ov !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL midreset_async got %b/%b/%b want 0/0/0", ov, a_ov, rdy); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (ov !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL midreset_lost got %b/%b want 0/1", ov, rdy); end
   endtask

   initial begin
      test_reset();
      test_i_type();
      test_back_to_back();
      test_u_z_j();
      test_illegal();
      test_skid();
      test_flush();
      test_skid0_ready();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate-generation stage for the decode path. Each cycle it accepts one instruction word plus PC over a valid/ready handshake. It classifies the instruction format, produces the XLEN-wide sign- or zero-extended immediate and the PC-relative target `pc + imm`, and flags illegal encodings. It sits between fetch and the register-read/execute stage, and its optional 2-entry skid buffer lets the ready path be fully registered.

## Interface
- `XLEN`, default 32: datapath width; legal values 32 and 64.
- `EN_ZICSR`, default 1: when 1, SYSTEM CSR-immediate forms (funct3[2]=1) decode as Z-format; when 0, SYSTEM with funct3≠0 is illegal.
- `SKID`, default 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single output register.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; discards all buffered entries.
- `in_valid` in 1: input entry valid.
- `in_ready` out 1: stage can accept an entry.
- `in_ir` in 32: instruction word.
- `in_pc` in XLEN: instruction address.
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: downstream accepts the entry.
- `out_imm` out XLEN: extended immediate.
- `out_target` out XLEN: `pc + imm`, modulo 2^XLEN.
- `out_fmt` out 3: format code (see Structure).
- `out_illegal` out 1: unrecognised or malformed encoding.
- `out_pc` out XLEN: PC passed through with the entry.

## Operation
- Decode rules:
  - `ir[1:0]`≠2'b11 → illegal.
  - OP-IMM, LOAD, JALR, MISC-MEM, and OP-IMM-32 (XLEN=64 only) → I: `{sext ir[31:20]}`.
  - STORE → S: `{sext ir[31:25], ir[11:7]}`.
  - BRANCH → B: `{sext ir[31], ir[7], ir[30:25], ir[11:8], 0}`.
  - LUI/AUIPC → U: `{sext ir[31:12], 12'b0}`.
  - JAL → J: `{sext ir[31], ir[19:12], ir[20], ir[30:21], 0}`.
  - SYSTEM with funct3[2]=1 and EN_ZICSR=1 → Z: zero-extend `ir[19:15]`.
  - SYSTEM with funct3=0 → NONE, legal.
  - OP, and OP-32 (XLEN=64 only) → NONE, imm=0.
  - Any other opcode → NONE, imm=0, illegal=1.
- All sign extension is from `ir[31]` to the full XLEN.
- `out_target` is always `out_pc + out_imm` with wrap-around, regardless of format; consumers ignore it where it is meaningless.
- An entry is accepted on a cycle with `in_valid && in_ready`. It is retired on a cycle with `out_valid && out_ready`.
- Entries leave in acceptance order, and none are dropped or duplicated.
- Output payload holds stable while `out_valid && !out_ready`.
- SKID=1 storage: a main register plus a skid register, with occupancy 0/1/2.
  - `in_ready` = occupancy<2, registered.
  - On occupancy 2 with retire, the skid entry moves to main.
  - Simultaneous accept and retire at occupancy 1 keeps occupancy at 1.
- SKID=0: `in_ready = !out_valid || out_ready` (combinational through `out_ready`).
- Flush:
  - On the edge where `flush`=1, occupancy becomes 0.
  - An input presented in the same cycle is discarded, even if `in_ready`=1.
  - Flush overrides accept and retire.
- Reset: asynchronous on `rst_n` low; the state reaches reset values immediately.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 entry/cycle while `out_ready`=1.
- Reset values:
  - `out_valid`=0.
  - `in_ready`=1 after reset deasserts (SKID=1 holds 0 while `rst_n` is low; SKID=0 follows the formula).
  - `out_imm`, `out_target`, `out_pc`=0.
  - `out_fmt`=NONE.
  - `out_illegal`=0.
- Full (SKID=1): the cycle after occupancy reaches 2, `in_ready`=0. It returns to 1 the cycle after the first retire.
- Empty: `out_valid`=0, and the payload keeps its last values (not checked).
- Reset asserted mid-stream: `out_valid` falls asynchronously and all entries are lost.

## Structure
- Shared package `imm_pkg`:
  - Opcode constants, including OP-IMM-32, OP-32 and SYSTEM.
  - 3-bit format codes: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- Sub-module `imm_decode`: purely combinational, parametrised by XLEN and EN_ZICSR; ir → imm, fmt, illegal.
- `imm_gen_pipe` instantiates `imm_decode` on the input side. It computes the target adder before the register, then adds the handshake and buffer.

## Test plan
- 0xFFF00093 (ADDI -1), pc 0x100 → next cycle: imm 0xFFFFFFFF, fmt I, target 0xFF, illegal 0.
- 0xFE20AE23 (SW -4), then 0xFE000CE3 (BEQ -8) at pc 0x100 → imm 0xFFFFFFFC fmt S; then imm 0xFFFFFFF8 fmt B, target 0xF8.
- 0x123450B7 (LUI) → imm 0x12345000 fmt U. 0x305FD073 (CSRRWI uimm 31) → imm 0x1F fmt Z. The same word with EN_ZICSR=0 → illegal 1.
- 0x00000000 and 0x0000007F → illegal 1, fmt NONE, imm 0.
- XLEN=64: 0xFFF00093 → imm 0xFFFF_FFFF_FFFF_FFFF.
- SKID=1, 5 back-to-back inputs with `out_ready` low for cycles 2–4:
  - 2 entries accepted, then `in_ready`=0.
  - All 5 entries emerge in order with no loss.
  - `flush` in a later busy cycle → `out_valid`=0 the next cycle.
  - `rst_n` low while `out_valid`=1 → `out_valid`=0 without waiting for a clock edge.
